dffram_wb_bridge: RTL and testbench

//   Wishbone classic slave that drives the single port of a 256x16 DFFRAM macro.

---
 rtl/dffram_pkg.sv | 21 ++
 rtl/dffram_clear_seq.sv | 33 +++
 rtl/dffram_wb_bridge.sv | 141 ++++++++++++++
 tb/tb_dffram_wb_bridge.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffram_pkg.sv
// dffram_pkg
//   Shared definitions for the Wishbone-to-DFFRAM bridge: the bridge FSM state
//   encoding and the default geometry of the 256x16 DFFRAM macro.
//   Imported by dffram_wb_bridge and dffram_clear_seq.
package dffram_pkg;

    localparam int DFF_AW    = 8;
    localparam int DFF_DW    = 16;
    localparam int DFF_WSIZE = DFF_DW / 8;

    // Word written into every location by the optional clear engine
    localparam logic [15:0] DFF_CLEAR_VAL = 16'h0000;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

endpackage

// File: rtl/dffram_clear_seq.sv
// dffram_clear_seq
//   Address sequencer for the RAM clear engine. Steps through every word
//   address once while 'run' is high and flags the final address.
// Ports
//   clk   in   1   rising-edge clock
//   rst   in   1   synchronous active-high reset, returns the count to 0
//   run   in   1   advance the address this cycle
//   addr  out  AW  address being cleared this cycle
//   done  out  1   high while run is set on the last address (all ones)
module dffram_clear_seq #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [AW-1:0] addr,
    output logic          done
);
    import dffram_pkg::*;

    // The counter wraps back to 0 after the last address, so a later re-entry
    // into the clear state (after a reset) always begins at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (run) begin
            addr <= addr + AW'(1);
        end
    end

    assign done = run && (addr == {AW{1'b1}});

endmodule

// File: rtl/dffram_wb_bridge.sv
// dffram_wb_bridge
//   Wishbone classic slave driving the single port of a DFFRAM macro.
//   Each accepted bus cycle produces exactly one RAM enable: writes are acked
//   the cycle after the request, reads two cycles after (one cycle for the
//   macro output to settle, then the registered data is returned with ack).
// Configuration
//   DFFRAM_CLEAR_EN : when defined, the RAM is filled with CLEAR_VAL after
//                     every reset; busy_o is high and bus requests wait.
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   wb_cyc_i/stb_i     bus cycle / request strobe
//   wb_we_i, wb_sel_i  write enable, byte-lane enables
//   wb_adr_i, wb_dat_i word address, write data
//   wb_dat_o, wb_ack_o read data, one-cycle acknowledge
//   busy_o             clear engine running
//   ram_en_o/we_o/a_o/di_o  EN0/WE0/A0/Di0 to the macro
//   ram_do_i           Do0 from the macro
module dffram_wb_bridge
    import dffram_pkg::*;
#(
    parameter int             AW        = DFF_AW,
    parameter int             DW        = DFF_DW,
    parameter int             WSIZE     = DFF_WSIZE,
    parameter logic [DW-1:0]  CLEAR_VAL = DW'(DFF_CLEAR_VAL)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [WSIZE-1:0] wb_sel_i,
    input  logic [AW-1:0]    wb_adr_i,
    input  logic [DW-1:0]    wb_dat_i,
    output logic [DW-1:0]    wb_dat_o,
    output logic             wb_ack_o,
    output logic             busy_o,
    output logic             ram_en_o,
    output logic [WSIZE-1:0] ram_we_o,
    output logic [AW-1:0]    ram_a_o,
    output logic [DW-1:0]    ram_di_o,
    input  logic [DW-1:0]    ram_do_i
);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] rd_data;
    logic          req;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef DFFRAM_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;

    logic [AW-1:0] clr_addr;
    logic          clr_done;

    dffram_clear_seq #(
        .AW(AW)
    ) u_clear_seq (
        .clk  (CLK),
        .rst  (RST),
        .run  (state == ST_CLEAR),
        .addr (clr_addr),
        .done (clr_done)
    );
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Do0 is valid during RD_WAIT (the macro captured the read at the end of
    // the request cycle); hold it so it is stable for the whole ACK cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data <= '0;
        end else if (state == ST_RD_WAIT && wb_cyc_i) begin
            rd_data <= ram_do_i;
        end
    end

    assign wb_dat_o = rd_data;

    // RAM strobes are combinational in the request cycle so the macro performs
    // the access on the same edge the FSM leaves IDLE. Everything is forced to
    // its idle value while RST is high so nothing reaches the macro.
    always_comb begin
        state_nxt = state;
        ram_en_o  = 1'b0;
        ram_we_o  = '0;
        ram_a_o   = '0;
        ram_di_o  = '0;
        wb_ack_o  = 1'b0;
        busy_o    = 1'b0;
        if (!RST) begin
            case (state)
                ST_CLEAR: begin
`ifdef DFFRAM_CLEAR_EN
                    busy_o   = 1'b1;
                    ram_en_o = 1'b1;
                    ram_we_o = {WSIZE{1'b1}};
                    ram_a_o  = clr_addr;
                    ram_di_o = CLEAR_VAL;
                    if (clr_done) begin
                        state_nxt = ST_IDLE;
                    end
`else
                    // Unreachable without the clear engine; fall back to idle.
                    ram_di_o  = CLEAR_VAL;
                    state_nxt = ST_IDLE;
`endif
                end
                ST_IDLE: begin
                    if (req) begin
                        ram_en_o  = 1'b1;
                        ram_a_o   = wb_adr_i;
                        ram_di_o  = wb_dat_i;
                        ram_we_o  = wb_we_i ? wb_sel_i : '0;
                        state_nxt = wb_we_i ? ST_ACK : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    state_nxt = wb_cyc_i ? ST_ACK : ST_IDLE;
                end
                ST_ACK: begin
                    // A strobe still high here belongs to the transfer being
                    // acknowledged, so the FSM never re-issues it.
                    wb_ack_o  = wb_cyc_i;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_wb_bridge.sv
// tb_dffram_wb_bridge
//   Self-checking bench for dffram_wb_bridge with a behavioural 256x16 DFFRAM
//   attached. Table-driven bus transfers plus hand-written sequences for
//   held strobe, cyc abort, reset during a transfer and (with
//   DFFRAM_CLEAR_EN) the clear engine. Expected read data is queued when a
//   read is issued and compared when the ack arrives.
module tb_dffram_wb_bridge;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_sel_i;
    logic [7:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        busy_o;
    logic        ram_en_o;
    logic [1:0]  ram_we_o;
    logic [7:0]  ram_a_o;
    logic [15:0] ram_di_o;
    logic [15:0] ram_do = 16'h0000;

    // Contents a location holds before the bus ever writes it
`ifdef DFFRAM_CLEAR_EN
    localparam logic [15:0] FILL = 16'h0000;
`else
    localparam logic [15:0] FILL = 16'hDEAD;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] expq[$];

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [7:0]  adr;
        logic [15:0] dat;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    always #5 CLK = ~CLK;

    dffram_wb_bridge dut (
        .CLK      (CLK),
        .RST      (RST),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .busy_o   (busy_o),
        .ram_en_o (ram_en_o),
        .ram_we_o (ram_we_o),
        .ram_a_o  (ram_a_o),
        .ram_di_o (ram_di_o),
        .ram_do_i (ram_do)
    );

    // Behavioural DFFRAM: byte-lane writes, Do0 updated on enabled reads
    logic [15:0] mem [0:255] = '{default: 16'hDEAD};

    always @(posedge CLK) begin
        if (ram_en_o) begin
            if (ram_we_o[0]) mem[ram_a_o][7:0]  <= ram_di_o[7:0];
            if (ram_we_o[1]) mem[ram_a_o][15:8] <= ram_di_o[15:8];
            if (ram_we_o == 2'b00) ram_do <= mem[ram_a_o];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idleBus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 2'b00;
        wb_adr_i = 8'h00;
        wb_dat_i = 16'h0000;
    endtask

    // One complete bus transfer; dat is write data or the expected read data
    task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [7:0] adr,
                                 input logic [15:0] dat, input int explat);
        int          lat;
        bit          got;
        logic [15:0] expd;
        @(negedge CLK);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_adr_i = adr;
        wb_dat_i = we ? dat : 16'h0000;
        if (!we) expq.push_back(dat);
        #1;
        checkOutput("req_en", 32'(ram_en_o), 32'd1);
        checkOutput("req_we", 32'(ram_we_o), we ? 32'(sel) : 32'd0);
        checkOutput("req_adr", 32'(ram_a_o), 32'(adr));
        if (we) checkOutput("req_di", 32'(ram_di_o), 32'(dat));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge CLK);
            lat++;
            if (wb_ack_o) got = 1'b1;
        end
        checkOutput("ack_seen", 32'(got), 32'd1);
        checkOutput("ack_latency", 32'(lat), 32'(explat));
        if (!we) begin
            expd = expq.pop_front();
            if (got) checkOutput("rd_data", 32'(wb_dat_o), 32'(expd));
        end
        idleBus();
    endtask

    task automatic waitNotBusy();
        int n = 0;
        while (busy_o && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("busy_release", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int n;
        int en_cnt;
        int ack_cnt;
        logic [15:0] rd_seen;

        vecs[0]  = '{1'b1, 2'b11, 8'h12, 16'hBEEF, 1};
        vecs[1]  = '{1'b0, 2'b11, 8'h12, 16'hBEEF, 2};
        vecs[2]  = '{1'b1, 2'b01, 8'h12, 16'h55AA, 1};
        vecs[3]  = '{1'b0, 2'b00, 8'h12, 16'hBEAA, 2};
        vecs[4]  = '{1'b1, 2'b11, 8'hFF, 16'h1111, 1};
        vecs[5]  = '{1'b1, 2'b11, 8'h00, 16'h2222, 1};
        vecs[6]  = '{1'b0, 2'b11, 8'hFF, 16'h1111, 2};
        vecs[7]  = '{1'b0, 2'b11, 8'h00, 16'h2222, 2};
        vecs[8]  = '{1'b1, 2'b00, 8'h34, 16'hFFFF, 1};
        vecs[9]  = '{1'b0, 2'b11, 8'h34, FILL, 2};
        vecs[10] = '{1'b1, 2'b10, 8'h80, 16'h7F00, 1};
        vecs[11] = '{1'b0, 2'b11, 8'h80, {8'h7F, FILL[7:0]}, 2};

        idleBus();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("rst_ack", 32'(wb_ack_o), 32'd0);
        checkOutput("rst_en", 32'(ram_en_o), 32'd0);
        checkOutput("rst_we", 32'(ram_we_o), 32'd0);
        checkOutput("rst_adr", 32'(ram_a_o), 32'd0);
        checkOutput("rst_di", 32'(ram_di_o), 32'd0);
        checkOutput("rst_dat", 32'(wb_dat_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);

`ifdef DFFRAM_CLEAR_EN
        // Let the clear run 100 cycles, then reset and expect a full restart
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        checkOutput("clear_busy_mid", 32'(busy_o), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 8'hFF;
        #1;
        n = 0;
        ack_cnt = 0;
        while (busy_o && n < 1000) begin
            n++;
            if (wb_ack_o) ack_cnt++;
            @(negedge CLK);
        end
        checkOutput("clear_cycles", 32'(n), 32'd256);
        checkOutput("clear_no_ack", 32'(ack_cnt), 32'd0);
        n = 0;
        while (!wb_ack_o && n < 8) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("clear_req_lat", 32'(n), 32'd2);
        checkOutput("clear_rd_ff", 32'(wb_dat_o), 32'(FILL));
        idleBus();
        applyStimulus(1'b0, 2'b11, 8'h00, FILL, 2);
`else
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("busy_tied_low", 32'(busy_o), 32'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].lat);
        end

        // Read with the strobe held through the ack cycle: one enable, one ack
        @(negedge CLK);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 8'h12;
        en_cnt  = 0;
        ack_cnt = 0;
        rd_seen = 16'h0000;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge CLK);
            if (ram_en_o) en_cnt++;
            if (wb_ack_o) begin
                ack_cnt++;
                rd_seen = wb_dat_o;
                idleBus();
            end
        end
        checkOutput("held_stb_en", 32'(en_cnt), 32'd1);
        checkOutput("held_stb_ack", 32'(ack_cnt), 32'd1);
        checkOutput("held_stb_data", 32'(rd_seen), 32'hBEAA);
        idleBus();

        // Drop cyc during RD_WAIT: no ack, then a normal read
        @(negedge CLK);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 8'hFF;
        @(negedge CLK);
        idleBus();
        ack_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (wb_ack_o) ack_cnt++;
            @(negedge CLK);
        end
        checkOutput("abort_no_ack", 32'(ack_cnt), 32'd0);
        applyStimulus(1'b0, 2'b11, 8'h00, 16'h2222, 2);

        // Reset while a read is in flight
        @(negedge CLK);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 8'hFF;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("midrst_ack", 32'(wb_ack_o), 32'd0);
        checkOutput("midrst_en", 32'(ram_en_o), 32'd0);
        checkOutput("midrst_dat", 32'(wb_dat_o), 32'd0);
        idleBus();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        waitNotBusy();
`ifdef DFFRAM_CLEAR_EN
        applyStimulus(1'b0, 2'b11, 8'hFF, FILL, 2);
`else
        applyStimulus(1'b0, 2'b11, 8'hFF, 16'h1111, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
